// File: rtl/ps2_key_tx.sv
// ps2_key_tx: keyboard-side PS/2 transmitter sending a key's make sequence.
// Define PS2_TX_BREAK_EN to add a HOLD pause and the break sequence (F0 ...).
module ps2_key_tx #(
    parameter int CLK_DIV     = 4000,
    parameter int GAP_CYCLES  = 2000,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int WAIT_MAX = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES
                                                         : HOLD_CYCLES;
    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(GAP_CYCLES - 1);
`ifdef PS2_TX_BREAK_EN
    localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(HOLD_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        FRAME,
        GAP,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    logic [8:0]        code;
    logic [HALF_W-1:0] half_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        bit_idx;
    logic [2:0]        byte_idx;
    logic              low_phase;

    logic [7:0]        cur_byte;
    logic [2:0]        seq_last;
    logic              nxt_bit;
`ifdef PS2_TX_BREAK_EN
    logic [2:0]        make_last;
`endif

    // Byte list: make = [E0] code, break = [E0] F0 code.
    always_comb begin
        cur_byte = code[7:0];
        if (code[8]) begin
            if (byte_idx == 3'd0) begin
                cur_byte = 8'hE0;
            end
`ifdef PS2_TX_BREAK_EN
            else if (byte_idx == 3'd2) begin
                cur_byte = 8'hE0;
            end else if (byte_idx == 3'd3) begin
                cur_byte = 8'hF0;
            end
        end else if (byte_idx == 3'd1) begin
            cur_byte = 8'hF0;
`endif
        end
    end

    always_comb begin
`ifdef PS2_TX_BREAK_EN
        make_last = code[8] ? 3'd1 : 3'd0;
        seq_last  = code[8] ? 3'd4 : 3'd2;
`else
        seq_last  = code[8] ? 3'd1 : 3'd0;
`endif
    end

    // Value of frame bit (bit_idx + 1): data LSB first, odd parity, stop.
    always_comb begin
        nxt_bit = 1'b1;
        if (bit_idx < 4'd8) begin
            nxt_bit = cur_byte[bit_idx[2:0]];
        end else if (bit_idx == 4'd8) begin
            nxt_bit = ~^cur_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code      <= '0;
            half_cnt  <= '0;
            wait_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            low_phase <= 1'b0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (key_valid) begin
                        code      <= key_code;
                        state     <= FRAME;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                        half_cnt  <= '0;
                        bit_idx   <= '0;
                        byte_idx  <= '0;
                        low_phase <= 1'b0;
                        ps2_clk   <= 1'b1;
                        ps2_data  <= 1'b0;
                    end
                end
                FRAME: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end else begin
                        half_cnt <= '0;
                        if (!low_phase) begin
                            low_phase <= 1'b1;
                            ps2_clk   <= 1'b0;
                        end else if (bit_idx != 4'd10) begin
                            low_phase <= 1'b0;
                            ps2_clk   <= 1'b1;
                            ps2_data  <= nxt_bit;
                            bit_idx   <= bit_idx + 4'd1;
                        end else begin
                            low_phase <= 1'b0;
                            ps2_clk   <= 1'b1;
                            ps2_data  <= 1'b1;
                            bit_idx   <= '0;
                            wait_cnt  <= '0;
                            if (byte_idx == seq_last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
`ifdef PS2_TX_BREAK_EN
                            else if (byte_idx == make_last) begin
                                state <= HOLD;
                            end
`endif
                            else begin
                                state <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (wait_cnt == GAP_LAST) begin
                        wait_cnt <= '0;
                        byte_idx <= byte_idx + 3'd1;
                        state    <= FRAME;
                        ps2_data <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
`ifdef PS2_TX_BREAK_EN
                HOLD: begin
                    if (wait_cnt == HOLD_LAST) begin
                        wait_cnt <= '0;
                        byte_idx <= byte_idx + 3'd1;
                        state    <= FRAME;
                        ps2_data <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
`endif
                DONE: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                    byte_idx  <= '0;
                end
                default: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                    ps2_clk   <= 1'b1;
                    ps2_data  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_tx.sv
// tb_ps2_key_tx: table + random keys for ps2_key_tx, checked against a byte-list
// and waveform model; follows PS2_TX_BREAK_EN the same way as the design.
`timescale 1ns/1ps
module tb_ps2_key_tx;

    localparam int D     = 4;
    localparam int G     = 8;
    localparam int H     = 16;
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [8:0] key_code = '0;
    logic       key_ready;
    logic       busy;
    logic       done;
    logic       ps2_clk;
    logic       ps2_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    ps2_key_tx #(
        .CLK_DIV(D),
        .GAP_CYCLES(G),
        .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ready(key_ready),
        .busy(busy),
        .done(done),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Host-side receiver: samples ps2_data on ps2_clk falling edges.
    logic [7:0]  rx_b[$];
    logic        rx_ok[$];
    int          rx_t[$];
    int          falls = 0;
    logic        m_prev = 1'b1;
    logic [10:0] m_sh = '0;
    int          m_nb = 0;
    int          m_t0 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_nb = 0;
                m_prev = 1'b1;
            end else begin
                if (m_prev && !ps2_clk) begin
                    falls++;
                    if (m_nb == 0) m_t0 = cyc;
                    m_sh[m_nb] = ps2_data;
                    m_nb++;
                    if (m_nb == 11) begin
                        rx_b.push_back(m_sh[8:1]);
                        rx_ok.push_back(m_sh[0] == 1'b0 && m_sh[10] == 1'b1 &&
                                        ($countones(m_sh[9:1]) % 2 == 1));
                        rx_t.push_back(m_t0);
                        m_nb = 0;
                    end
                end
                m_prev = ps2_clk;
            end
        end
    end

    // Reference model: byte list and frame start cycles for one key.
    logic [7:0] exp_q[$];
    int         exp_s[$];

    task automatic build_model(input logic [8:0] c, input int acc);
        int s;
        int make_n;
        s = acc;
        exp_q.delete();
        exp_s.delete();
        if (c[8]) exp_q.push_back(8'hE0);
        exp_q.push_back(c[7:0]);
        make_n = exp_q.size();
`ifdef PS2_TX_BREAK_EN
        if (c[8]) exp_q.push_back(8'hE0);
        exp_q.push_back(8'hF0);
        exp_q.push_back(c[7:0]);
`endif
        foreach (exp_q[i]) begin
            exp_s.push_back(s);
            s += 22 * D + ((i == make_n - 1) ? H : G);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9) return ($countones(b) % 2 == 0);
        return 1'b1;
    endfunction

    function automatic logic [1:0] exp_lines(input int c);
        int o;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c >= exp_s[i] && c < exp_s[i] + 22 * D) begin
                o = c - exp_s[i];
                return {((o % (2 * D)) < D), fbit(exp_q[i], o / (2 * D))};
            end
        end
        return 2'b11;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (key_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", n < LIMIT, 1);
    endtask

    task automatic run_key(input logic [8:0] c, input int inj);
        int n;
        int acc;
        int mis;
        logic [1:0] e;
        wait_ready();
        rx_b.delete();
        rx_ok.delete();
        rx_t.delete();
        key_code = c;
        key_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        key_valid = 1'b0;
        key_code = 9'($urandom);
        build_model(c, acc);
        chk("accept", {busy, key_ready, ps2_clk, ps2_data}, 4'b1010);
        n = 0;
        mis = 0;
        forever begin
            e = exp_lines(cyc);
            if ({ps2_clk, ps2_data} !== e ||
                done !== (cyc == exp_s[$] + 22 * D)) mis++;
            key_valid = 1'b0;
            if (inj > 0 && cyc == acc + inj) begin
                key_valid = 1'b1;
                key_code = 9'h01E;
            end
            if (done === 1'b1 || n > LIMIT) break;
            n++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk("done_seen", done, 1);
        chk("done_t", cyc, exp_s[$] + 22 * D);
        chk("wave", mis, 0);
        chk("nframes", rx_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_b.size(); i++) begin
            chk($sformatf("byte%0d", i), rx_b[i], exp_q[i]);
            chk($sformatf("frame%0d", i), rx_ok[i], 1);
            chk($sformatf("fall_t%0d", i), rx_t[i], exp_s[i] + D);
        end
        @(negedge clk);
        chk("idle", {key_ready, busy, done, ps2_clk, ps2_data}, 5'b10011);
    endtask

    typedef struct {
        logic [8:0]      code;
        int              n;
        logic [0:4][7:0] b;
    } vec_t;

    vec_t vecs[6];
    int   t_acc;
    int   t_dc;
    int   t_n;
    int   t_q;
    int   t_f0;

    initial begin
`ifdef PS2_TX_BREAK_EN
        vecs[0] = '{9'h045, 3, {8'h45, 8'hF0, 8'h45, 8'h00, 8'h00}};
        vecs[1] = '{9'h15A, 5, {8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A}};
        vecs[2] = '{9'h016, 3, {8'h16, 8'hF0, 8'h16, 8'h00, 8'h00}};
        vecs[3] = '{9'h1F0, 5, {8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hF0}};
        vecs[4] = '{9'h0FF, 3, {8'hFF, 8'hF0, 8'hFF, 8'h00, 8'h00}};
        vecs[5] = '{9'h100, 5, {8'hE0, 8'h00, 8'hE0, 8'hF0, 8'h00}};
`else
        vecs[0] = '{9'h045, 1, {8'h45, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{9'h15A, 2, {8'hE0, 8'h5A, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{9'h016, 1, {8'h16, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{9'h1F0, 2, {8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{9'h0FF, 1, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{9'h100, 2, {8'hE0, 8'h00, 8'h00, 8'h00, 8'h00}};
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", key_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clk", ps2_clk, 1);
        chk("rst_data", ps2_data, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_key(vecs[i].code, (i % 2 == 1) ? 20 : 0);
            chk($sformatf("tbl%0d_n", i), rx_b.size(), vecs[i].n);
            for (int j = 0; j < vecs[i].n && j < rx_b.size(); j++)
                chk($sformatf("tbl%0d_b%0d", i, j), rx_b[j], vecs[i].b[j]);
        end

        for (int i = 0; i < 16; i++) begin
            run_key(9'($urandom_range(0, 511)),
                    (i % 3 == 0) ? int'($urandom_range(2, 80)) : 0);
        end

        // Held key_valid: second acceptance right after one idle cycle.
        wait_ready();
        key_code = 9'h15A;
        key_valid = 1'b1;
        t_n = 0;
        do begin
            @(negedge clk);
            t_n++;
        end while (done !== 1'b1 && t_n < LIMIT);
        chk("b2b_done1", done, 1);
        t_dc = cyc;
        @(negedge clk);
        chk("b2b_gap", {key_ready, busy}, 2'b10);
        @(negedge clk);
        chk("b2b_acc", {key_ready, busy, ps2_data}, 3'b010);
        chk("b2b_acc_t", cyc, t_dc + 2);
        t_acc = cyc;
        key_valid = 1'b0;
        build_model(9'h15A, t_acc);
        t_n = 0;
        while (done !== 1'b1 && t_n < LIMIT) begin
            @(negedge clk);
            t_n++;
        end
        chk("b2b_done2_t", cyc, exp_s[$] + 22 * D);
        @(negedge clk);

        // Reset asserted during the low phase of bit 5.
        wait_ready();
        key_code = 9'h045;
        key_valid = 1'b1;
        @(negedge clk);
        t_acc = cyc;
        key_valid = 1'b0;
        t_n = 0;
        while (cyc < t_acc + 11 * D + 1 && t_n < LIMIT) begin
            @(negedge clk);
            t_n++;
        end
        chk("pre_rst_clk", ps2_clk, 0);
        chk("pre_rst_data", ps2_data, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk", ps2_clk, 1);
        chk("mid_rst_data", ps2_data, 1);
        chk("mid_rst_ready", key_ready, 1);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t_f0 = falls;
        t_q = 0;
        repeat (300) begin
            @(negedge clk);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) t_q++;
        end
        chk("quiet_lines", t_q, 0);
        chk("quiet_falls", falls - t_f0, 0);
        chk("post_rst_ready", key_ready, 1);

        run_key(9'h016, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
